counter_nbit_multichannel: RTL and testbench
============================================

// Module: counter_nbit_multichannel
// PURPOSE
//  NUM_CH independent WIDTH-bit up/down counters sharing one clock domain.
//  Each channel has its own enable, synchronous clear, parallel load and direction.
//  A shared parameter selects modulo-MAX_COUNT wrap or saturation.
//  Micro-benchmark for exercising carry chains, control-signal fan-out and multi-bit FF packing.
// PARAMETERS
//  NUM_CH     2   number of independent counter channels (>=1)
//  WIDTH      4   bits per channel (>=2)
//  MAX_COUNT  15  terminal value, count range 0..MAX_COUNT (must be <= 2**WIDTH-1)
//  WRAP_MODE  1   1: wrap at terminal value; 0: saturate (hold) at terminal value
//  INIT_VAL   0   value loaded into every channel on reset (must be <= MAX_COUNT)
// PORTS
//  clk       in   1              counter clock, rising edge
//  rstn      in   1              asynchronous active-low reset
//  en        in   NUM_CH         per-channel count enable
//  clr       in   NUM_CH         per-channel synchronous clear to 0
//  load      in   NUM_CH         per-channel synchronous parallel load
//  load_val  in   NUM_CH*WIDTH   load data; channel i at [i*WIDTH +: WIDTH]
//  dir       in   NUM_CH         per-channel direction: 1 up, 0 down
//  q         out  NUM_CH*WIDTH   counter values; channel i at [i*WIDTH +: WIDTH]
//  tc        out  NUM_CH         registered terminal-count pulse, one cycle
//  ovf       out  NUM_CH         sticky overflow/underflow flag
// BEHAVIOUR
//  Reset (rstn=0, async, no clock needed): q[i]=INIT_VAL, tc=0, ovf=0 for all i.
//  Reset release is synchronous to the next rising clk edge; no count on the release edge itself.
//  Per channel, per rising edge, priority: clr > load > en > hold.
//   clr=1:   q<=0, ovf<=0, tc<=0.
//   load=1:  q<=min(load_val_i, MAX_COUNT), tc<=0, ovf unchanged.
//   en=1, dir=1:
//    q<MAX_COUNT  -> q<=q+1.
//    q==MAX_COUNT -> WRAP_MODE=1: q<=0, tc<=1, ovf<=1.
//                    WRAP_MODE=0: q holds, tc<=1, ovf<=1.
//   en=1, dir=0:
//    q>0  -> q<=q-1.
//    q==0 -> WRAP_MODE=1: q<=MAX_COUNT, tc<=1, ovf<=1.
//            WRAP_MODE=0: q holds, tc<=1, ovf<=1.
//   en=0, no clr/load: q holds, tc<=0.
//  tc is high for exactly the cycle after a terminal event.
//   In saturate mode, tc re-asserts every enabled cycle spent at the limit.
//  ovf stays high until the channel's clr or rstn.
//  Latency: q reflects a command one clock after the sampling edge; there is no combinational path from inputs to outputs.
//  Channels are fully independent; simultaneous events on different channels do not interact.
//  Arithmetic is unsigned, modulo MAX_COUNT+1 in wrap mode; q never exceeds MAX_COUNT.
//  dir may change on any cycle; a change takes effect at that edge.
//  Reset asserted mid-count overrides everything immediately; in-flight load or clear is discarded.
// TESTING
//  Reset: rstn=0 with INIT_VAL=0 -> q=0x00, tc=2'b00, ovf=2'b00; release, en=0 for 3 clk -> q holds at 0.
//  Up-count wrap, ch0, MAX_COUNT=15, WRAP=1: en0=1, dir0=1, 16 clk -> q0 goes 0..15 then 0; tc0 high for 1 cycle; ovf0=1; q1 stays 0.
//  Down-count saturate, WRAP=0, ch1: load 3, then en1=1, dir1=0 for 6 clk -> q1 goes 3,2,1,0,0,0; tc1 high on the last 3 cycles; ovf1=1.
//  Priority: clr0=load0=en0=1, load_val=9 -> q0=0, ovf0=0.
//   Next cycle: load0=en0=1 -> q0=9.
//   Then: load_val=12 with MAX_COUNT=10 -> q0=10 (clamped).
//  Independence: ch0 counts up while ch1 counts down from 5 for 4 clk -> q0=4, q1=1; tc=2'b00.
//  Async reset mid-operation: assert rstn low between edges while q0=7 and load0=1 -> q0=INIT_VAL immediately; ovf cleared; load discarded.

Source files
------------

// File: rtl/counter_nbit_multichannel.sv
// rtl/counter_nbit_multichannel.sv - NUM_CH independent up/down counters with wrap or saturate
module counter_nbit_multichannel #(
  parameter int NUM_CH    = 2,
  parameter int WIDTH     = 4,
  parameter int MAX_COUNT = 15,
  parameter int WRAP_MODE = 1,
  parameter int INIT_VAL  = 0
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [NUM_CH-1:0]       en,
  input  logic [NUM_CH-1:0]       clr,
  input  logic [NUM_CH-1:0]       load,
  input  logic [NUM_CH*WIDTH-1:0] load_val,
  input  logic [NUM_CH-1:0]       dir,
  output logic [NUM_CH*WIDTH-1:0] q,
  output logic [NUM_CH-1:0]       tc,
  output logic [NUM_CH-1:0]       ovf
);

  localparam logic [WIDTH-1:0] MAX_V  = WIDTH'(MAX_COUNT);
  localparam logic [WIDTH-1:0] INIT_V = WIDTH'(INIT_VAL);
  localparam logic [WIDTH-1:0] ONE_V  = WIDTH'(1);
  localparam bit               WRAP   = (WRAP_MODE != 0);

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] ld_val;
    logic             tc_q, tc_d;
    logic             ovf_q, ovf_d;

    assign ld_val = load_val[i*WIDTH +: WIDTH];

    // Next-state: clear beats load beats count; tc only pulses on a terminal event.
    always_comb begin
      cnt_d = cnt_q;
      tc_d  = 1'b0;
      ovf_d = ovf_q;
      if (clr[i]) begin
        cnt_d = '0;
        ovf_d = 1'b0;
      end else if (load[i]) begin
        cnt_d = (ld_val > MAX_V) ? MAX_V : ld_val;
      end else if (en[i]) begin
        if (dir[i]) begin
          if (cnt_q >= MAX_V) begin
            tc_d  = 1'b1;
            ovf_d = 1'b1;
            cnt_d = WRAP ? '0 : MAX_V;
          end else begin
            cnt_d = cnt_q + ONE_V;
          end
        end else begin
          if (cnt_q == '0) begin
            tc_d  = 1'b1;
            ovf_d = 1'b1;
            cnt_d = WRAP ? MAX_V : '0;
          end else begin
            cnt_d = cnt_q - ONE_V;
          end
        end
      end
    end

    // Channel state registers; reset wins over any in-flight command.
    always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
        cnt_q <= INIT_V;
        tc_q  <= 1'b0;
        ovf_q <= 1'b0;
      end else begin
        cnt_q <= cnt_d;
        tc_q  <= tc_d;
        ovf_q <= ovf_d;
      end
    end

    assign q[i*WIDTH +: WIDTH] = cnt_q;
    assign tc[i]               = tc_q;
    assign ovf[i]              = ovf_q;
  end

endmodule

// File: tb/tb_counter_nbit_multichannel.sv
// tb/tb_counter_nbit_multichannel.sv - directed vector bench for counter_nbit_multichannel
module tb_counter_nbit_multichannel;

  logic       clk;
  logic       rstn;
  logic [1:0] en, clr, load, dir;
  logic [7:0] load_val;
  logic [7:0] q_w, q_s;
  logic [1:0] tc_w, tc_s, ovf_w, ovf_s;

  int checks = 0;
  int errors = 0;

  // wrap instance, range 0..15
  counter_nbit_multichannel #(.NUM_CH(2), .WIDTH(4), .MAX_COUNT(15), .WRAP_MODE(1), .INIT_VAL(0)) u_w (
    .clk(clk), .rstn(rstn), .en(en), .clr(clr), .load(load), .load_val(load_val),
    .dir(dir), .q(q_w), .tc(tc_w), .ovf(ovf_w)
  );

  // saturate instance, range 0..10
  counter_nbit_multichannel #(.NUM_CH(2), .WIDTH(4), .MAX_COUNT(10), .WRAP_MODE(0), .INIT_VAL(0)) u_s (
    .clk(clk), .rstn(rstn), .en(en), .clr(clr), .load(load), .load_val(load_val),
    .dir(dir), .q(q_s), .tc(tc_s), .ovf(ovf_s)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic       sel;
    logic [1:0] en, dir, clr, load;
    logic [7:0] lv;
    logic [7:0] eq;
    logic [1:0] etc;
    logic [1:0] eovf;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input string name, input logic sel, input logic [1:0] e, input logic [1:0] d,
                     input logic [1:0] c, input logic [1:0] l, input logic [7:0] lv,
                     input logic [7:0] eq, input logic [1:0] etc, input logic [1:0] eovf);
    vec_t v;
    v.name = name; v.sel = sel; v.en = e; v.dir = d; v.clr = c; v.load = l;
    v.lv = lv; v.eq = eq; v.etc = etc; v.eovf = eovf;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [1:0] e, input logic [1:0] d, input logic [1:0] c,
                       input logic [1:0] l, input logic [7:0] lv);
    en = e; dir = d; clr = c; load = l; load_val = lv;
  endtask

  initial begin
    // idle after reset release
    for (int k = 0; k < 3; k++) add("idle_hold", 0, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00);
    // ch0 up-count through the wrap point
    for (int k = 1; k <= 16; k++)
      add("up_wrap", 0, 2'b01, 2'b01, 2'b00, 2'b00, 8'h00, 8'(k % 16),
          (k == 16) ? 2'b01 : 2'b00, (k == 16) ? 2'b01 : 2'b00);
    add("up_wrap_after", 0, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 2'b01);
    // ch1 down-count into saturation
    add("sat_clr",   1, 2'b00, 2'b00, 2'b11, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00);
    add("sat_load3", 1, 2'b00, 2'b00, 2'b00, 2'b10, 8'h30, 8'h30, 2'b00, 2'b00);
    add("sat_dn",    1, 2'b10, 2'b00, 2'b00, 2'b00, 8'h00, 8'h20, 2'b00, 2'b00);
    add("sat_dn",    1, 2'b10, 2'b00, 2'b00, 2'b00, 8'h00, 8'h10, 2'b00, 2'b00);
    add("sat_dn",    1, 2'b10, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00);
    for (int k = 0; k < 3; k++) add("sat_dn_hold", 1, 2'b10, 2'b00, 2'b00, 2'b00, 8'h00, 8'h00, 2'b10, 2'b10);
    // priority on ch0 and load clamp at MAX_COUNT=10
    add("prio_clr",   1, 2'b01, 2'b01, 2'b01, 2'b01, 8'h09, 8'h00, 2'b00, 2'b10);
    add("prio_load",  1, 2'b01, 2'b01, 2'b00, 2'b01, 8'h09, 8'h09, 2'b00, 2'b10);
    add("load_clamp", 1, 2'b00, 2'b00, 2'b00, 2'b01, 8'h0C, 8'h0A, 2'b00, 2'b10);
    // independence: ch0 up from 0, ch1 down from 5
    add("ind_clr",  0, 2'b00, 2'b00, 2'b11, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00);
    add("ind_load", 0, 2'b00, 2'b00, 2'b00, 2'b10, 8'h50, 8'h50, 2'b00, 2'b00);
    add("ind_cnt",  0, 2'b11, 2'b01, 2'b00, 2'b00, 8'h00, 8'h41, 2'b00, 2'b00);
    add("ind_cnt",  0, 2'b11, 2'b01, 2'b00, 2'b00, 8'h00, 8'h32, 2'b00, 2'b00);
    add("ind_cnt",  0, 2'b11, 2'b01, 2'b00, 2'b00, 8'h00, 8'h23, 2'b00, 2'b00);
    add("ind_cnt",  0, 2'b11, 2'b01, 2'b00, 2'b00, 8'h00, 8'h14, 2'b00, 2'b00);
    // ch1 down-wrap from 0 to 15
    add("dn_wrap_clr", 0, 2'b00, 2'b00, 2'b11, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00);
    add("dn_wrap",     0, 2'b10, 2'b00, 2'b00, 2'b00, 8'h00, 8'hF0, 2'b10, 2'b10);
    add("dn_wrap_nxt", 0, 2'b10, 2'b00, 2'b00, 2'b00, 8'h00, 8'hE0, 2'b00, 2'b10);
    // ch0 up-count saturating at 10
    add("satup_clr",  1, 2'b00, 2'b00, 2'b11, 2'b00, 8'h00, 8'h00, 2'b00, 2'b00);
    add("satup_load", 1, 2'b00, 2'b00, 2'b00, 2'b01, 8'h0A, 8'h0A, 2'b00, 2'b00);
    add("satup_hold", 1, 2'b01, 2'b01, 2'b00, 2'b00, 8'h00, 8'h0A, 2'b01, 2'b01);
    add("satup_hold", 1, 2'b01, 2'b01, 2'b00, 2'b00, 8'h00, 8'h0A, 2'b01, 2'b01);
    add("satup_idle", 1, 2'b00, 2'b00, 2'b00, 2'b00, 8'h00, 8'h0A, 2'b00, 2'b01);
    add("load7_ovf",  1, 2'b00, 2'b00, 2'b00, 2'b01, 8'h07, 8'h07, 2'b00, 2'b01);

    // reset state, no clock edge needed
    rstn = 1'b0;
    drive(2'b00, 2'b00, 2'b00, 2'b00, 8'h00);
    #1;
    chk("rst_q_w", q_w, 8'h00);
    chk("rst_tc_w", {6'd0, tc_w}, 8'h00);
    chk("rst_ovf_w", {6'd0, ovf_w}, 8'h00);
    chk("rst_q_s", q_s, 8'h00);
    chk("rst_tc_s", {6'd0, tc_s}, 8'h00);
    chk("rst_ovf_s", {6'd0, ovf_s}, 8'h00);
    @(negedge clk);
    rstn = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].en, vecs[i].dir, vecs[i].clr, vecs[i].load, vecs[i].lv);
      step();
      if (vecs[i].sel) begin
        chk({vecs[i].name, "_q"},   q_s, vecs[i].eq);
        chk({vecs[i].name, "_tc"},  {6'd0, tc_s}, {6'd0, vecs[i].etc});
        chk({vecs[i].name, "_ovf"}, {6'd0, ovf_s}, {6'd0, vecs[i].eovf});
      end else begin
        chk({vecs[i].name, "_q"},   q_w, vecs[i].eq);
        chk({vecs[i].name, "_tc"},  {6'd0, tc_w}, {6'd0, vecs[i].etc});
        chk({vecs[i].name, "_ovf"}, {6'd0, ovf_w}, {6'd0, vecs[i].eovf});
      end
    end

    // async reset between edges while q0=7, ovf0=1 and a load is pending
    drive(2'b00, 2'b00, 2'b00, 2'b01, 8'h09);
    #2;
    rstn = 1'b0;
    #1;
    chk("arst_q_s", q_s, 8'h00);
    chk("arst_ovf_s", {6'd0, ovf_s}, 8'h00);
    chk("arst_q_w", q_w, 8'h00);
    chk("arst_ovf_w", {6'd0, ovf_w}, 8'h00);
    step();
    chk("arst_hold_q_s", q_s, 8'h00);
    #3;
    rstn = 1'b1;
    drive(2'b00, 2'b00, 2'b00, 2'b00, 8'h00);
    step();
    chk("arst_rel_q_s", q_s, 8'h00);
    chk("arst_rel_tc_s", {6'd0, tc_s}, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
